// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// Enum encodings double as arbiter request indices (FETCH=0, DATA=1).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } port_t;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
  localparam logic [3:0]  BE_WORD  = 4'hF;

endpackage

// File: rtl/arb_rr2.sv
// Two-input round-robin picker, purely combinational (zero latency, no state).
// On a tie the port not granted last wins; a lone requester always wins.
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       win,
  output logic       any
);

  always_comb begin
    any = |req;
    if (&req) begin
      win = ~last;
    end else begin
      win = req[1];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store: grant in IDLE, command next cycle, response passed through.
// One transaction outstanding; new requests wait outside IDLE, command held until mem_gnt, response bounded by watchdog.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  output logic          if_err,

  input  logic          d_req,
  input  logic          d_we,
  input  logic [3:0]    d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,

  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,

  output logic          busy
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  port_t         last_grant;
  port_t         owner;
  logic          hold_we;
  logic [3:0]    hold_be;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_wdata;
  logic [CW-1:0] wd_cnt;

  logic          arb_win;
  logic          arb_any;
  logic          grant;
  logic          expire;
  logic          resp_done;

  arb_rr2 u_arb (
    .req  ({d_req, if_req}),
    .last (last_grant),
    .win  (arb_win),
    .any  (arb_any)
  );

  // Reset masks the grant so a requester never sees gnt for a command that is then discarded.
  assign grant     = (state == IDLE) && arb_any && !rst;
  assign expire    = (TIMEOUT != 0) && (state == RESP) && !mem_rvalid && (wd_cnt == CNT_LAST);
  assign resp_done = (state == RESP) && (mem_rvalid || expire);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_any) state_nxt = ADDR;
      ADDR:    if (mem_gnt) state_nxt = RESP;
      RESP:    if (mem_rvalid || expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= FETCH;
      owner      <= FETCH;
      hold_we    <= 1'b0;
      hold_be    <= 4'h0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      wd_cnt     <= '0;
    end else begin
      if (grant) begin
        last_grant <= port_t'(arb_win);
        owner      <= port_t'(arb_win);
        if (arb_win) begin
          hold_we    <= d_we;
          hold_be    <= d_be;
          hold_addr  <= d_addr;
          hold_wdata <= d_wdata;
        end else begin
          hold_we    <= 1'b0;
          hold_be    <= BE_WORD;
          hold_addr  <= if_addr;
          hold_wdata <= '0;
        end
      end
      // Cleared on the accepting ADDR cycle so the first RESP cycle sees zero.
      if ((state == ADDR) && mem_gnt) begin
        wd_cnt <= '0;
      end else if ((state == RESP) && !mem_rvalid) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    if_gnt    = grant && !arb_win;
    d_gnt     = grant && arb_win;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    if_err    = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    d_err     = 1'b0;
    busy      = (state != IDLE);

    if (state == ADDR) begin
      mem_req   = 1'b1;
      mem_we    = hold_we;
      mem_be    = hold_be;
      mem_addr  = hold_addr;
      mem_wdata = hold_wdata;
    end

    // A real response in the expiry cycle wins over the error response.
    if (resp_done && !rst) begin
      if (owner == DATA) begin
        d_rvalid = 1'b1;
        d_rdata  = mem_rvalid ? mem_rdata : DW'(ERR_DATA);
        d_err    = !mem_rvalid;
      end else begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rvalid ? mem_rdata : DW'(ERR_DATA);
        if_err    = !mem_rvalid;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: driver pushes expected grants, commands and responses,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_port_arbiter;

  localparam int TO = 4;
  localparam bit P_FETCH = 1'b0;
  localparam bit P_DATA  = 1'b1;
  localparam logic [31:0] EXP_ERR = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_s;

  typedef struct {
    bit          port;
    logic [31:0] data;
    logic        err;
  } rsp_s;

  bit   gnt_q[$];
  cmd_s cmd_q[$];
  rsp_s rsp_q[$];
  bit   last_win;
  int   checks;
  int   errors;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .if_err     (if_err),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_be       (d_be),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .d_err      (d_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},    {30'd0, if_gnt, d_gnt}, 32'd0);
    chk({tag, "_rvalid"}, {30'd0, if_rvalid, d_rvalid}, 32'd0);
    chk({tag, "_err"},    {30'd0, if_err, d_err}, 32'd0);
    chk({tag, "_rdata"},  if_rdata | d_rdata, 32'd0);
    chk({tag, "_mem_ctl"}, {27'd0, mem_req, mem_we, mem_be}, 32'd0);
    chk({tag, "_mem_dat"}, mem_addr | mem_wdata, 32'd0);
    chk({tag, "_busy"},   {31'd0, busy}, 32'd0);
  endtask

  task automatic noise();
    if_req  = 1'($urandom_range(0, 1));
    d_req   = 1'($urandom_range(0, 1));
    if_addr = $urandom;
    d_we    = 1'($urandom_range(0, 1));
    d_be    = 4'($urandom);
    d_addr  = $urandom;
    d_wdata = $urandom;
  endtask

  // One full transaction: requests in an IDLE cycle, memory accept after gdel stall cycles,
  // memory response in RESP cycle rdel (or the watchdog response in RESP cycle TO-1).
  task automatic run_txn(input bit f, input bit d, input logic [31:0] fa,
                         input logic we, input logic [3:0] be, input logic [31:0] da,
                         input logic [31:0] wd, input int gdel, input int rdel,
                         input logic [31:0] rdat, input bit stray);
    cmd_s c;
    bit   w;
    int   n;
    @(posedge clk); #1;
    if_req = f; if_addr = fa;
    d_req = d; d_we = we; d_be = be; d_addr = da; d_wdata = wd;
    mem_gnt = 1'b0; mem_rvalid = stray; mem_rdata = $urandom;
    w = (f && d) ? ~last_win : d;
    last_win = w;
    if (w) c = '{we: we, be: be, addr: da, wdata: wd};
    else   c = '{we: 1'b0, be: 4'hF, addr: fa, wdata: 32'd0};
    gnt_q.push_back(w);
    cmd_q.push_back(c);
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_mem_req", {31'd0, mem_req}, 32'd0);
    chk("gnt_now", {31'd0, if_gnt | d_gnt}, 32'd1);

    n = 0;
    forever begin
      @(posedge clk); #1;
      noise();
      mem_gnt = (n >= gdel);
      mem_rvalid = stray && ($urandom_range(0, 1) == 1);
      mem_rdata = $urandom;
      @(negedge clk);
      chk("addr_busy", {31'd0, busy}, 32'd1);
      if (mem_req && mem_gnt) break;
      n++;
      if (n > gdel + 8) break;
    end
    chk("accept_latency", n, gdel);

    for (int k = 0; k < 64; k++) begin
      @(posedge clk); #1;
      noise();
      mem_gnt = 1'($urandom_range(0, 1));
      mem_rvalid = 1'b0;
      mem_rdata = $urandom;
      if (k == rdel) begin
        mem_rvalid = 1'b1;
        mem_rdata = rdat;
        rsp_q.push_back('{port: w, data: rdat, err: 1'b0});
      end else if (TO != 0 && k == TO - 1) begin
        rsp_q.push_back('{port: w, data: EXP_ERR, err: 1'b1});
      end
      @(negedge clk);
      chk("resp_busy", {31'd0, busy}, 32'd1);
      if (k == rdel || k == TO - 1) begin
        chk("rsp_present", {31'd0, if_rvalid | d_rvalid}, 32'd1);
        break;
      end
    end
  endtask

  // Abandon a fetch with reset while it sits in ADDR or RESP; a later mem_rvalid must be ignored.
  task automatic reset_mid(input bit in_resp);
    logic [31:0] a;
    a = $urandom;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = a; d_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    last_win = P_FETCH;
    gnt_q.push_back(P_FETCH);
    cmd_q.push_back('{we: 1'b0, be: 4'hF, addr: a, wdata: 32'd0});
    @(posedge clk); #1;
    if_req = 1'b0; mem_gnt = in_resp;
    if (in_resp) begin
      @(posedge clk); #1;
      mem_gnt = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    gnt_q.delete(); cmd_q.delete(); rsp_q.delete();
    last_win = P_FETCH;
    @(negedge clk);
    chk_all_zero(in_resp ? "rst_resp" : "rst_addr");
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = $urandom;
    @(negedge clk);
    chk("stray_after_rst", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
  endtask

  initial begin : monitor
    cmd_s c;
    rsp_s r;
    bit   w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (if_gnt || d_gnt) begin
          chk("gnt_onehot", {30'd0, if_gnt, d_gnt} & {30'd0, if_gnt, 1'b1}, {30'd0, if_gnt, !if_gnt});
          chk("gnt_expected", {31'd0, gnt_q.size() != 0}, 32'd1);
          if (gnt_q.size() != 0) begin
            w = gnt_q.pop_front();
            chk("gnt_port", {31'd0, d_gnt}, {31'd0, w});
          end
        end
        if (mem_req) begin
          chk("cmd_expected", {31'd0, cmd_q.size() != 0}, 32'd1);
          if (cmd_q.size() != 0) begin
            c = cmd_q[0];
            chk("mem_we", {31'd0, mem_we}, {31'd0, c.we});
            chk("mem_be", {28'd0, mem_be}, {28'd0, c.be});
            chk("mem_addr", mem_addr, c.addr);
            chk("mem_wdata", mem_wdata, c.wdata);
            if (mem_gnt) void'(cmd_q.pop_front());
          end
        end
        if (if_rvalid || d_rvalid) begin
          chk("rsp_onehot", {30'd0, if_rvalid, d_rvalid} & {30'd0, if_rvalid, 1'b1}, {30'd0, if_rvalid, !if_rvalid});
          chk("rsp_expected", {31'd0, rsp_q.size() != 0}, 32'd1);
          if (rsp_q.size() != 0) begin
            r = rsp_q.pop_front();
            chk("rsp_port", {31'd0, d_rvalid}, {31'd0, r.port});
            chk("rsp_data", if_rvalid ? if_rdata : d_rdata, r.data);
            chk("rsp_err", {31'd0, if_rvalid ? if_err : d_err}, {31'd0, r.err});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin : driver
    int r;
    checks = 0;
    errors = 0;
    last_win = P_FETCH;
    rst = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("in_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("post_reset");

    // Fetch only, minimum latency.
    run_txn(1, 0, 32'h0000_0010, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0050_0093, 0);

    // Ties: data wins first, then strict alternation.
    for (int i = 0; i < 8; i++)
      run_txn(1, 1, 32'h100 + 32'(i * 4), 1, 4'h3, 32'h2000 + 32'(i * 4), 32'h0000_CAFE,
              0, $urandom_range(0, 2), $urandom, 0);

    // Backpressure with strays in ADDR.
    run_txn(0, 1, 32'h0, 1, 4'hC, 32'h0000_3000, 32'h1234_5678, 5, 1, $urandom, 1);

    // Watchdog expiry, then a real response landing exactly on expiry.
    run_txn(0, 1, 32'h0, 0, 4'hF, 32'h0000_4000, 32'h0, 0, 20, $urandom, 0);
    run_txn(1, 0, 32'h0000_0040, 0, 4'h0, 32'h0, 32'h0, 1, 20, $urandom, 0);
    run_txn(0, 1, 32'h0, 0, 4'hF, 32'h0000_4004, 32'h0, 0, TO - 1, 32'h0BAD_F00D, 0);

    reset_mid(1);
    reset_mid(0);
    run_txn(1, 1, 32'h0000_0080, 0, 4'h1, 32'h0000_5000, 32'h0, 0, 0, $urandom, 0);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(1, 3);
      run_txn(r[0], r[1], $urandom, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 5), $urandom, 1'($urandom_range(0, 1)));
    end

    @(posedge clk); #1;
    if_req = 0; d_req = 0; mem_gnt = 0; mem_rvalid = 0;
    repeat (2) @(posedge clk);
    // Stray in IDLE.
    #1 mem_rvalid = 1'b1;
    @(negedge clk);
    chk("stray_idle", {30'd0, if_rvalid, d_rvalid}, 32'd0);
    chk("idle_end_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk("gnt_q_drained", gnt_q.size(), 32'd0);
    chk("cmd_q_drained", cmd_q.size(), 32'd0);
    chk("rsp_q_drained", rsp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single unified memory port between the instruction-fetch requester and the load/store requester. It accepts one request per cycle from each side, picks a winner round-robin, and holds that command stable on the memory port until the memory accepts it. It routes the response back to the owning requester and bounds each response wait with a watchdog. It sits between the PC/fetch logic and data_mem on one side and the shared memory on the other.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 64, max cycles waiting for mem_rvalid; 0 disables the watchdog
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- if_req / if_addr  in  1 / AW  fetch request and address; the fetch port is read-only
- if_gnt  out  1  fetch command accepted this cycle
- if_rvalid / if_rdata / if_err  out  1 / DW / 1  fetch response
- d_req / d_we / d_be / d_addr / d_wdata  in  1 / 1 / 4 / AW / DW  load/store request
- d_gnt  out  1  data command accepted this cycle
- d_rvalid / d_rdata / d_err  out  1 / DW / 1  data response; stores also get a response
- mem_req / mem_we / mem_be / mem_addr / mem_wdata  out  1 / 1 / 4 / AW / DW  command to memory
- mem_gnt  in  1  memory accepts the command when mem_req && mem_gnt
- mem_rvalid / mem_rdata  in  1 / DW  memory response
- busy  out  1  high whenever state != IDLE

## Operation
- FSM states:
  - IDLE → ADDR: when either request is high.
  - ADDR → RESP: on mem_gnt.
  - RESP → IDLE: on mem_rvalid or on timeout.
- Only one transaction is outstanding at a time.
- IDLE arbitration:
  - With a single requester, that requester wins.
  - With both requesting, the port not granted last wins.
  - last_grant resets to FETCH, so the data port wins the first tie.
- In the grant cycle:
  - The winner's gnt is asserted combinationally from state, req and last_grant.
  - The command is registered into the hold registers and last_grant updates.
  - A requester must hold req, addr and data until it sees gnt. It may change them after.
- Fetch commands are registered as we=0, be=4'hF, wdata=0.
- ADDR: mem_req=1 and the mem_* outputs are driven from the hold registers, unchanged until mem_gnt.
- RESP:
  - mem_rvalid is passed combinationally to the owner's rvalid, with rdata=mem_rdata and err=0.
  - Only the owner's rvalid asserts; the other port's rvalid stays 0.
- Watchdog:
  - The counter clears on entering RESP and increments each RESP cycle without mem_rvalid.
  - When TIMEOUT≠0 and the counter reaches TIMEOUT−1 without mem_rvalid: owner rvalid=1, err=1, rdata=ERR_DATA (32'hDEAD_BEEF), then go to IDLE.
  - mem_rvalid in the same cycle as expiry wins: normal response, err=0.
- A mem_rvalid seen in IDLE or ADDR is a stray. It is ignored: no port rvalid is asserted.
- No gnt is given outside IDLE. New requests simply wait.

## Timing
- Reset values:
  - state=IDLE, last_grant=FETCH, hold registers and watchdog counter = 0.
  - Every output is 0: gnt, rvalid, err, rdata, mem_* and busy.
- Reset has priority over every event. Reset during ADDR or RESP abandons the transaction: mem_req drops the cycle after reset is sampled, and no response is delivered.
- Minimum latency, with req in cycle 0:
  - gnt in cycle 0.
  - mem_req in cycle 1; with mem_gnt in cycle 1 the FSM enters RESP in cycle 2.
  - mem_rvalid in cycle 2 gives port rvalid in cycle 2.
- Throughput is at most one transaction per 3 cycles. The IDLE cycle after RESP may grant immediately.
- The timeout response appears in the TIMEOUT-th RESP cycle.

## Structure
- Package mem_arb_pkg holds:
  - state_t {IDLE, ADDR, RESP}
  - port_t {FETCH, DATA}
  - ERR_DATA
  - the default BE_WORD = 4'hF
- Sub-module arb_rr2: a 2-input round-robin picker. Inputs req[1:0], last; outputs win and any. Purely combinational.
- The top level holds the FSM, hold registers, owner register and watchdog counter.

## Test plan
- Fetch only: if_req=1 with if_addr=32'h0000_0010, mem_gnt=1 and memory latency 1 → if_gnt in cycle 0; mem_addr=0x10, mem_we=0, mem_be=F in cycle 1; if_rvalid in cycle 2 with if_rdata=mem_rdata=0x00500093.
- Tie after reset: both requesting with d_we=1, d_be=4'h3, d_wdata=0xCAFE → data wins first and mem_we=1, mem_be=3. The next tie grants fetch. Alternation continues for 8 transactions.
- Backpressure: mem_gnt held low for 5 cycles → mem_addr and mem_wdata stay stable, busy=1, no second gnt. Releasing mem_gnt completes the transaction normally.
- Timeout: TIMEOUT=4 and no mem_rvalid → d_rvalid=1, d_err=1, d_rdata=0xDEADBEEF in the 4th RESP cycle, then IDLE. Repeat with mem_rvalid exactly at expiry → err=0.
- Reset in RESP: rst pulsed for 1 cycle → all outputs 0 the next cycle, and a later mem_rvalid produces no port rvalid. Stray mem_rvalid in IDLE → also ignored.
